// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
// Shared definitions for the decode stage: RV opcode constants, ALUOp class
// encodings, immediate-format selector and the control-bundle struct that
// the decode table produces and the output register holds.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD     = 2'b00,
    ALUOP_BRANCH  = 2'b01,
    ALUOP_FUNCT   = 2'b10,
    ALUOP_ILLEGAL = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_B    = 2'd3
  } imm_kind_e;

  typedef struct packed {
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
  localparam ctrl_t CTRL_ILLEGAL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ILLEGAL};
  localparam ctrl_t CTRL_LOAD    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
  localparam ctrl_t CTRL_STORE   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
  localparam ctrl_t CTRL_OP      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
  localparam ctrl_t CTRL_OP_IMM  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
  localparam ctrl_t CTRL_BRANCH  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_BRANCH};

endpackage

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile
// Integer register file: two combinational read ports, one write port shared
// between the writeback path and a debug/load path (debug wins), optional
// same-cycle write-to-read forwarding.
// Ports:
//   clk, rst_n              clock, async active-low reset (clears all entries)
//   raddr1/raddr2 -> rdata  read ports; index 0 or >= NREG reads zero
//   wb_en/wb_rd/wb_data     writeback write request
//   dbg_we/dbg_addr/dbg_data debug write request, overrides writeback
module decode_stage_regfile #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_data
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs [NREG];

  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  // x0 and indices beyond the implemented file are neither written nor read.
  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREG);
  endfunction

  // A debug write suppresses writeback for the whole cycle, even when the
  // debug index itself is ignored.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = '0;
    if (dbg_we) begin
      wr_en   = in_range(dbg_addr);
      wr_addr = dbg_addr;
      wr_data = dbg_data;
    end else if (wb_en) begin
      wr_en   = in_range(wb_rd);
      wr_addr = wb_rd;
      wr_data = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (in_range(raddr1)) begin
      if ((BYPASS != 0) && wr_en && (wr_addr == raddr1)) begin
        rdata1 = wr_data;
      end else begin
        rdata1 = regs[raddr1[AW-1:0]];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (in_range(raddr2)) begin
      if ((BYPASS != 0) && wr_en && (wr_addr == raddr2)) begin
        rdata2 = wr_data;
      end else begin
        rdata2 = regs[raddr2[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Single registered decode stage for a small RV64 pipeline. Decodes the
// incoming instruction combinationally, reads operands from the register
// file at the moment of transfer and holds the whole bundle in one output
// register with valid/ready handshaking on both sides.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready, pc_in, instruction   upstream handshake and payload
//   flush                           kill the held bundle, block a transfer
//   wb_en/wb_rd/wb_data             register writeback
//   dbg_we/dbg_addr/dbg_data        debug/load register write (priority)
//   out_valid/out_ready             downstream handshake
//   pc_out, read_data1/2, immediate registered PC, operands, immediate
//   rs1_out, rs2_out, write_register_out   register indices
//   ALUSrc..Branch, ALUOp, ALU_control_input, illegal   control bundle
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instruction,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic [XLEN-1:0] immediate,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [4:0]      write_register_out,
  output logic            ALUSrc,
  output logic            MemToReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic [1:0]      ALUOp,
  output logic [3:0]      ALU_control_input,
  output logic            illegal
);

  logic [6:0]      opcode;
  ctrl_t           ctrl_d;
  imm_kind_e       imm_kind;
  logic            illegal_d;
  logic            uses_rd;
  logic            uses_rs2;
  logic [XLEN-1:0] imm_d;
  logic [4:0]      rs1_d;
  logic [4:0]      rs2_d;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            xfer;

  ctrl_t           ctrl_q;

  assign opcode = instruction[6:0];

  always_comb begin
    ctrl_d    = CTRL_ILLEGAL;
    imm_kind  = IMM_NONE;
    illegal_d = 1'b1;
    uses_rd   = 1'b0;
    uses_rs2  = 1'b1;
    case (opcode)
      OPC_LOAD: begin
        ctrl_d    = CTRL_LOAD;
        imm_kind  = IMM_I;
        illegal_d = 1'b0;
        uses_rd   = 1'b1;
        uses_rs2  = 1'b0;
      end
      OPC_STORE: begin
        ctrl_d    = CTRL_STORE;
        imm_kind  = IMM_S;
        illegal_d = 1'b0;
      end
      OPC_OP: begin
        ctrl_d    = CTRL_OP;
        illegal_d = 1'b0;
        uses_rd   = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_d    = CTRL_OP_IMM;
        imm_kind  = IMM_I;
        illegal_d = 1'b0;
        uses_rd   = 1'b1;
        uses_rs2  = 1'b0;
      end
      OPC_BRANCH: begin
        ctrl_d    = CTRL_BRANCH;
        imm_kind  = IMM_B;
        illegal_d = 1'b0;
      end
      default: begin
        ctrl_d    = CTRL_ILLEGAL;
        illegal_d = 1'b1;
      end
    endcase
  end

  // instr[31] is the sign bit of every immediate format decoded here.
  always_comb begin
    imm_d = '0;
    case (imm_kind)
      IMM_I:   imm_d = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
      IMM_S:   imm_d = {{(XLEN-12){instruction[31]}}, instruction[31:25],
                        instruction[11:7]};
      IMM_B:   imm_d = {{(XLEN-13){instruction[31]}}, instruction[31],
                        instruction[7], instruction[30:25], instruction[11:8],
                        1'b0};
      default: imm_d = '0;
    endcase
  end

  assign rs1_d = instruction[19:15];
  assign rs2_d = uses_rs2 ? instruction[24:20] : 5'd0;
  assign rd_d  = uses_rd ? instruction[11:7] : 5'd0;

  // Reading with the decoded rs2 index makes read_data2 zero for formats
  // without a second source register.
  decode_stage_regfile #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (rs1_d),
    .raddr2   (rs2_d),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign in_ready = !out_valid || out_ready;
  // flush leaves in_ready alone but still refuses the transfer.
  assign xfer     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid          <= 1'b0;
      pc_out             <= '0;
      read_data1         <= '0;
      read_data2         <= '0;
      immediate          <= '0;
      rs1_out            <= '0;
      rs2_out            <= '0;
      write_register_out <= '0;
      ctrl_q             <= CTRL_RESET;
      ALU_control_input  <= '0;
      illegal            <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid          <= 1'b1;
      pc_out             <= pc_in;
      read_data1         <= rdata1;
      read_data2         <= rdata2;
      immediate          <= imm_d;
      rs1_out            <= rs1_d;
      rs2_out            <= rs2_d;
      write_register_out <= rd_d;
      ctrl_q             <= ctrl_d;
      ALU_control_input  <= {instruction[30], instruction[14:12]};
      illegal            <= illegal_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign ALUSrc   = ctrl_q.alu_src;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  ctl;   // ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic        ill;
  } bund_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, wb_en, dbg_we, out_ready;
  logic [63:0] pc_in, wb_data, dbg_data;
  logic [31:0] instruction;
  logic [4:0]  wb_rd, dbg_addr;

  logic        in_ready, out_valid;
  logic [63:0] pc_out, read_data1, read_data2, immediate;
  logic [4:0]  rs1_out, rs2_out, write_register_out;
  logic        ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, illegal;
  logic [1:0]  ALUOp;
  logic [3:0]  ALU_control_input;

  logic        nb_in_ready, nb_out_valid;
  logic [63:0] nb_pc_out, nb_read_data1, nb_read_data2, nb_immediate;
  logic [4:0]  nb_rs1_out, nb_rs2_out, nb_write_register_out;
  logic        nb_ALUSrc, nb_MemToReg, nb_RegWrite, nb_MemRead, nb_MemWrite, nb_Branch, nb_illegal;
  logic [1:0]  nb_ALUOp;
  logic [3:0]  nb_ALU_control_input;

  int    errors = 0;
  int    checks = 0;
  bund_t exp_q[$];
  bund_t act, nb_act, mon_e, stall_e, dummy;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction(instruction), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .write_register_out(write_register_out),
    .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .ALU_control_input(ALU_control_input), .illegal(illegal)
  );

  decode_stage #(.XLEN(64), .NREG(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready),
    .pc_in(pc_in), .instruction(instruction), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .out_valid(nb_out_valid), .out_ready(out_ready), .pc_out(nb_pc_out),
    .read_data1(nb_read_data1), .read_data2(nb_read_data2), .immediate(nb_immediate),
    .rs1_out(nb_rs1_out), .rs2_out(nb_rs2_out), .write_register_out(nb_write_register_out),
    .ALUSrc(nb_ALUSrc), .MemToReg(nb_MemToReg), .RegWrite(nb_RegWrite), .MemRead(nb_MemRead),
    .MemWrite(nb_MemWrite), .Branch(nb_Branch), .ALUOp(nb_ALUOp),
    .ALU_control_input(nb_ALU_control_input), .illegal(nb_illegal)
  );

  always_comb begin
    act.pc     = pc_out;
    act.rd1    = read_data1;
    act.rd2    = read_data2;
    act.imm    = immediate;
    act.rs1    = rs1_out;
    act.rs2    = rs2_out;
    act.rd     = write_register_out;
    act.ctl    = {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch};
    act.aluop  = ALUOp;
    act.aluctl = ALU_control_input;
    act.ill    = illegal;
  end

  always_comb begin
    nb_act.pc     = nb_pc_out;
    nb_act.rd1    = nb_read_data1;
    nb_act.rd2    = nb_read_data2;
    nb_act.imm    = nb_immediate;
    nb_act.rs1    = nb_rs1_out;
    nb_act.rs2    = nb_rs2_out;
    nb_act.rd     = nb_write_register_out;
    nb_act.ctl    = {nb_ALUSrc, nb_MemToReg, nb_RegWrite, nb_MemRead, nb_MemWrite, nb_Branch};
    nb_act.aluop  = nb_ALUOp;
    nb_act.aluctl = nb_ALU_control_input;
    nb_act.ill    = nb_illegal;
  end

  function automatic bund_t mk(input logic [63:0] pc, rd1, rd2, imm,
                               input logic [4:0] rs1, rs2, rd,
                               input logic [5:0] ctl, input logic [1:0] aluop,
                               input logic [3:0] aluctl, input logic ill);
    bund_t b;
    b.pc = pc; b.rd1 = rd1; b.rd2 = rd2; b.imm = imm;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd;
    b.ctl = ctl; b.aluop = aluop; b.aluctl = aluctl; b.ill = ill;
    return b;
  endfunction

  task automatic show_bundle(input string name, input bund_t got, input bund_t want);
    $display("FAIL %s: got pc=%h rd1=%h rd2=%h imm=%h rs1=%0d rs2=%0d rd=%0d ctl=%b aluop=%b aluctl=%b ill=%b | want pc=%h rd1=%h rd2=%h imm=%h rs1=%0d rs2=%0d rd=%0d ctl=%b aluop=%b aluctl=%b ill=%b",
             name, got.pc, got.rd1, got.rd2, got.imm, got.rs1, got.rs2, got.rd, got.ctl, got.aluop, got.aluctl, got.ill,
             want.pc, want.rd1, want.rd2, want.imm, want.rs1, want.rs2, want.rd, want.ctl, want.aluop, want.aluctl, want.ill);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk_bundle(input string name, input bund_t got, input bund_t want);
    checks++;
    if (got !== want) begin
      errors++;
      show_bundle(name, got, want);
    end
  endtask

  // Monitor: every bundle the downstream accepts is compared against the
  // oldest expectation issued by the stimulus.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bundle: got pc=%h want none", pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (act !== mon_e) begin
          errors++;
          show_bundle("bundle", act, mon_e);
        end
      end
    end
  end

  task automatic send(input logic [63:0] pc, input logic [31:0] ins,
                      input bit push, input bund_t e);
    int n;
    pc_in       = pc;
    instruction = ins;
    in_valid    = 1'b1;
    if (push) exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for pc=%h", pc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [63:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_data = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
  endtask

  localparam logic [31:0] I_LD   = 32'h0081_3283;  // ld   x5, 8(x2)
  localparam logic [31:0] I_BEQ  = 32'hFE20_8EE3;  // beq  x1, x2, -4
  localparam logic [31:0] I_SUB  = 32'h4020_8333;  // sub  x6, x1, x2
  localparam logic [31:0] I_SD   = 32'hFE20_BC23;  // sd   x2, -8(x1)
  localparam logic [31:0] I_ADDI = 32'hFFF0_0493;  // addi x9, x0, -1
  localparam logic [31:0] I_ADD3 = 32'h0001_8533;  // add  x10, x3, x0
  localparam logic [31:0] I_MV7  = 32'h0003_8413;  // addi x8, x7, 0
  localparam logic [31:0] I_ILL  = 32'h0030_A07F;  // opcode 1111111

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dummy = '0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_in = '0; instruction = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_data = '0;

    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_pc_out", pc_out, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    dbg_write(5'd2, 64'h100);
    dbg_write(5'd1, 64'h55);
    // debug and writeback to x3 in the same cycle: debug value must win
    dbg_we = 1'b1; dbg_addr = 5'd3; dbg_data = 64'h11;
    wb_en  = 1'b1; wb_rd    = 5'd3; wb_data  = 64'h22;
    @(posedge clk); #1;
    dbg_we = 1'b0; wb_en = 1'b0;
    dbg_write(5'd0, 64'hFF);

    out_ready = 1'b1;
    send(64'h1000, I_LD,   1, mk(64'h1000, 64'h100, 64'h0, 64'h8, 5'd2, 5'd0, 5'd5, 6'b111100, 2'b00, 4'b0011, 1'b0));
    send(64'h1004, I_BEQ,  1, mk(64'h1004, 64'h55, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 5'd2, 5'd0, 6'b000001, 2'b01, 4'b1000, 1'b0));
    send(64'h1008, I_SUB,  1, mk(64'h1008, 64'h55, 64'h100, 64'h0, 5'd1, 5'd2, 5'd6, 6'b001000, 2'b10, 4'b1000, 1'b0));
    send(64'h100C, I_SD,   1, mk(64'h100C, 64'h55, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 5'd2, 5'd0, 6'b100010, 2'b00, 4'b1011, 1'b0));
    send(64'h1010, I_ADDI, 1, mk(64'h1010, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 5'd9, 6'b101000, 2'b10, 4'b1000, 1'b0));
    send(64'h1014, I_ADD3, 1, mk(64'h1014, 64'h11, 64'h0, 64'h0, 5'd3, 5'd0, 5'd10, 6'b001000, 2'b10, 4'b0000, 1'b0));

    // writeback to x7 in the very cycle x7 is read
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hDEAD;
    send(64'h1018, I_MV7,  1, mk(64'h1018, 64'hDEAD, 64'h0, 64'h0, 5'd7, 5'd0, 5'd8, 6'b101000, 2'b10, 4'b0000, 1'b0));
    wb_en = 1'b0;
    chk_bundle("nobypass_old_value", nb_act,
               mk(64'h1018, 64'h0, 64'h0, 64'h0, 5'd7, 5'd0, 5'd8, 6'b101000, 2'b10, 4'b0000, 1'b0));
    chk("nobypass_valid", {62'd0, nb_out_valid, nb_in_ready}, 64'd3);
    send(64'h101C, I_MV7,  1, mk(64'h101C, 64'hDEAD, 64'h0, 64'h0, 5'd7, 5'd0, 5'd8, 6'b101000, 2'b10, 4'b0000, 1'b0));
    chk("nobypass_written", nb_read_data1, 64'hDEAD);
    send(64'h1020, I_ILL,  1, mk(64'h1020, 64'h55, 64'h11, 64'h0, 5'd1, 5'd3, 5'd0, 6'b000000, 2'b11, 4'b0010, 1'b1));
    @(posedge clk); @(posedge clk); #1;

    // stall: held bundle must not move while a new one waits
    out_ready = 1'b0;
    stall_e = mk(64'h2000, 64'h55, 64'h100, 64'h0, 5'd1, 5'd2, 5'd6, 6'b001000, 2'b10, 4'b1000, 1'b0);
    send(64'h2000, I_SUB, 1, stall_e);
    pc_in = 64'h2004; instruction = I_BEQ; in_valid = 1'b1;
    exp_q.push_back(mk(64'h2004, 64'h55, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 5'd2, 5'd0, 6'b000001, 2'b01, 4'b1000, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk_bundle("stall_hold", act, stall_e);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_next_loaded", {pc_out[62:0], out_valid}, {64'h2004 << 1} | 64'd1);
    @(posedge clk); #1;

    // flush kills the held bundle and blocks a same-cycle transfer
    out_ready = 1'b0;
    send(64'h3000, I_ADDI, 0, dummy);
    flush = 1'b1; out_ready = 1'b1;
    pc_in = 64'h3004; instruction = I_LD; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_blocked_xfer", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // reset in the middle of a stall, with a debug write attempted under reset
    out_ready = 1'b0;
    send(64'h4000, I_ADDI, 0, dummy);
    pc_in = 64'h4004; instruction = I_LD; in_valid = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid_ready", {62'd0, out_valid, in_ready}, 64'd1);
    chk("async_reset_pc", pc_out, 64'd0);
    chk("async_reset_rd1", read_data1, 64'd0);
    in_valid = 1'b0;
    dbg_we = 1'b1; dbg_addr = 5'd3; dbg_data = 64'h77;
    @(posedge clk); @(posedge clk); #1;
    dbg_we = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(64'h5000, I_ADD3, 1, mk(64'h5000, 64'h0, 64'h0, 64'h0, 5'd3, 5'd0, 5'd10, 6'b001000, 2'b10, 4'b0000, 1'b0));
    send(64'h5004, I_LD,   1, mk(64'h5004, 64'h0, 64'h0, 64'h8, 5'd2, 5'd0, 5'd5, 6'b111100, 2'b00, 4'b0011, 1'b0));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, ≤32).
REQ-003 SHALL have parameter BYPASS, default 1, same-cycle write-to-read forwarding enable.
REQ-004 Ports, in this order:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- pc_in  in  XLEN  instruction PC
- instruction  in  32  RV instruction word
- flush  in  1  kill held output
- wb_en  in  1  writeback enable
- wb_rd  in  5  writeback index
- wb_data  in  XLEN  writeback value
- dbg_we  in  1  debug/load register write
- dbg_addr  in  5  debug write index
- dbg_data  in  XLEN  debug write value
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- pc_out  out  XLEN  registered PC
- read_data1, read_data2  out  XLEN  operands
- immediate  out  XLEN  sign-extended immediate
- rs1_out, rs2_out, write_register_out  out  5  indices
- ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch  out  1  controls
- ALUOp  out  2  ALU class
- ALU_control_input  out  4  {instr[30],instr[14:12]}
- illegal  out  1  unrecognised opcode

Function
REQ-005 Output bundle SHALL be one registered stage; in_ready = !out_valid | out_ready.
REQ-006 Transfer on in_valid & in_ready: bundle loads next edge, out_valid=1.
REQ-007 out_valid & !out_ready SHALL hold every output bit-stable.
REQ-008 out_valid & out_ready & !in_valid SHALL clear out_valid next edge.
REQ-009 flush SHALL clear out_valid next edge and block any same-cycle transfer; in_ready unaffected.
REQ-010 Decode table (opcode -> ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,ALUOp):
- 0000011 ld: 1,1,1,1,0,0,00; imm instr[31:20]
- 0100011 sd: 1,0,0,0,1,0,00; imm {instr[31:25],instr[11:7]}
- 0110011 R: 0,0,1,0,0,0,10; imm 0
- 0010011 OP-IMM: 1,0,1,0,0,0,10; imm instr[31:20]
- 1100011 beq: 0,0,0,0,0,1,01; imm {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
- other: all 0, ALUOp 11, imm 0, illegal=1.
REQ-011 Immediate SHALL sign-extend from its top bit to XLEN.
REQ-012 write_register_out = instr[11:7] for ld/R/OP-IMM, else 0; rs2_out = 0 for ld/OP-IMM, else instr[24:20]; rs1_out = instr[19:15].
REQ-013 Register reads SHALL be sampled at transfer; index 0 reads 0; index ≥ NREG reads 0.
REQ-014 Register writes on rising edge; writes to index 0 or ≥ NREG ignored.
REQ-015 dbg_we SHALL take priority; wb_en write suppressed in a cycle with dbg_we.
REQ-016 BYPASS=1: read index equal to an effective same-cycle write index (nonzero) SHALL capture the written value; BYPASS=0 captures old value.
REQ-017 Register writes SHALL proceed regardless of in_valid, stall or flush.

Reset
REQ-018 rst_n low SHALL immediately clear out_valid, all bundle outputs to 0, all registers to 0.
REQ-019 in_ready SHALL be 1 during and after reset.
REQ-020 Reset mid-stall SHALL discard the held bundle; no writes occur while rst_n low.

Structure
REQ-021 Shared package SHALL hold opcode constants, ALUOp encodings and a control-bundle struct typedef.
REQ-022 Register file SHALL be sub-module regfile (2R/1W plus debug port, bypass option); decode table remains combinational in decode_stage.

Verification
REQ-023 ld x5,8(x2) with x2=0x100, out_ready=1 -> next cycle out_valid=1, read_data1=0x100, immediate=8, write_register_out=5, MemRead=1.
REQ-024 beq with imm field -4 -> immediate=0xFFFF_FFFF_FFFF_FFFC, Branch=1, ALUOp=01, write_register_out=0.
REQ-025 out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged; out_ready=1 -> held bundle leaves, new one loads next edge.
REQ-026 wb_en x7=0xDEAD same cycle as transfer reading x7, BYPASS=1 -> read_data1=0xDEAD; BYPASS=0 -> old value.
REQ-027 dbg_we x3=0x11 and wb_en x3=0x22 same cycle -> x3=0x11; write to x0 -> x0 reads 0.
REQ-028 opcode 1111111 -> illegal=1, ALUOp=11; flush while out_valid=1 -> out_valid=0 next edge; rst_n low mid-stall -> out_valid=0 immediately.
